ila_capture_engine: RTL and testbench
=====================================

Name: ila_capture_engine

Overview:
Parametrised next-generation internal logic analyzer capture core. It continuously writes a probed bus into a circular buffer once armed. A programmable trigger unit (mask/compare, edge or external) decides when to stop, after a programmable holdoff. The captured window then streams out oldest-first over a valid/ready interface to the readout/dump logic.

Parameters:
DATA_WIDTH, 32, width of probed bus i_data
ADDR_WIDTH, 10, buffer address width; depth DEPTH = 2**ADDR_WIDTH
HOLDOFF_WIDTH, 16, width of i_holdoff

Ports:
clk  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high; returns block to IDLE
i_arm  in  1  single-cycle pulse; starts a new capture from IDLE
i_data  in  DATA_WIDTH  probed signals
i_trigger  in  1  external trigger input
i_trig_mode  in  2  00 pattern level, 01 pattern rising edge, 10 external, 11 force (trigger immediately when primed)
i_trig_mask  in  DATA_WIDTH  bits compared in pattern modes
i_trig_value  in  DATA_WIDTH  compare value
i_holdoff  in  HOLDOFF_WIDTH  samples written after trigger sample
o_primed  out  1  buffer filled at least once since arm
o_triggered  out  1  trigger accepted
o_stopped  out  1  writing halted, readout pending/active
o_trig_addr  out  ADDR_WIDTH  buffer address of trigger sample
o_valid  out  1  readout sample valid
i_ready  in  1  downstream accepts sample
o_data  out  DATA_WIDTH  readout sample
o_last  out  1  marks final (DEPTH-th) readout sample

Behaviour:
- Reset: all outputs 0, state IDLE, write pointer 0, holdoff counter 0. Reset mid-capture or mid-readout aborts immediately; buffer contents undefined afterwards.
- States: IDLE -> FILL (i_arm) -> ARMED (DEPTH samples written) -> HOLDOFF (trigger) -> READOUT (holdoff done) -> IDLE (o_last handshake).
- FILL/ARMED/HOLDOFF: one sample written per cycle at wptr; wptr wraps DEPTH-1 -> 0. o_primed rises the cycle after the DEPTH-th write, held until IDLE.
- Trigger evaluated only in ARMED; triggers in FILL are ignored. match = ((i_data ^ i_trig_value) & i_trig_mask) == 0. Mode 01 fires on match now and no match on the previous sample; the previous-match register is updated in all write states, so an edge straddling FILL->ARMED counts.
- Trigger sample is written the same cycle; o_trig_addr latches its address; o_triggered rises next cycle.
- HOLDOFF writes exactly i_holdoff further samples (latched at trigger; later changes ignored), then stops. i_holdoff=0: trigger sample is the last written. i_holdoff >= DEPTH is legal; the trigger sample is overwritten and o_trig_addr is then stale. This is documented, not an error.
- o_stopped rises the cycle after the final write; the trigger sample sits at offset DEPTH-1-i_holdoff from oldest when i_holdoff < DEPTH.
- READOUT: raddr starts at the stopped wptr (oldest sample) and wraps. RAM read latency is 1 cycle. A one-entry prefetch/skid register keeps o_data/o_valid stable while i_ready=0; o_valid never drops before handshake. Full throughput is 1 sample/cycle. Exactly DEPTH handshakes; o_last is asserted with the DEPTH-th.
- After the final handshake the block returns to IDLE: o_stopped, o_triggered and o_primed clear. i_arm outside IDLE is ignored.

Optional Feature:
ILA_TIMESTAMP_EN defined: a 32-bit counter clears on i_arm and increments each write cycle. It is stored alongside each sample, and o_data widens to DATA_WIDTH+32 with the timestamp in the upper 32 bits. Undefined: no counter; o_data is DATA_WIDTH.

Decomposition:
- Package ila_pkg: state encoding (IDLE, FILL, ARMED, HOLDOFF, READOUT), trigger-mode constants (TRIG_LEVEL, TRIG_EDGE, TRIG_EXT, TRIG_FORCE), timestamp width constant.
- Sub-module ila_trigger_unit: mask/compare, edge detect, mode mux. Outputs a 1-cycle fire pulse qualified by ARMED.

Test Plan:
- ADDR_WIDTH=4, i_data=counter from 0, mode 11, i_holdoff=3, arm at counter 0 -> trigger at sample 16, stop after sample 19. Readout is 4..19; o_last on 19; o_trig_addr=0.
- Mode 00, mask=0xFF, value=0x20, holdoff=0 -> readout ends exactly on the 0x20 sample. A match during FILL does not trigger.
- Mode 01 with data holding 0x20 for 10 cycles -> a single trigger on the first match only. A level hold does not retrigger.
- Readout with i_ready toggling 1,0,0,1 pseudo-randomly -> DEPTH samples, none duplicated or skipped. o_data stable while o_valid & !i_ready.
- Reset asserted in HOLDOFF, then re-arm -> all flags 0 the cycle after reset. A new capture completes normally.
- With ILA_TIMESTAMP_EN defined: timestamps are consecutive in readout. Trigger-sample timestamp = DEPTH for the force-mode test.

Source files
------------

// File: rtl/ila_pkg.sv
// Shared types and constants for the ILA capture engine: FSM state encoding,
// trigger-mode codes and the timestamp width used by the optional timestamp feature.
package ila_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        ARMED   = 3'd2,
        HOLDOFF = 3'd3,
        READOUT = 3'd4
    } state_t;

    localparam logic [1:0] TRIG_LEVEL = 2'b00;
    localparam logic [1:0] TRIG_EDGE  = 2'b01;
    localparam logic [1:0] TRIG_EXT   = 2'b10;
    localparam logic [1:0] TRIG_FORCE = 2'b11;

    localparam int TS_WIDTH = 32;

    function automatic logic is_write_state(input state_t s);
        return (s == FILL) || (s == ARMED) || (s == HOLDOFF);
    endfunction

endpackage

// File: rtl/ila_trigger_unit.sv
// Trigger decision: mask/compare, rising-edge detect on the match, mode select.
// The fire output is a combinational pulse so the trigger sample address can be latched in the same cycle.
module ila_trigger_unit
    import ila_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] mask,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [1:0]            mode,
    input  logic                  ext_trigger,
    input  logic                  sample_en,
    input  logic                  armed,
    output logic                  fire
);

    logic match_s;
    logic prev_match_r;
    logic cond_s;

    assign match_s = (((data ^ value) & mask) == {DATA_WIDTH{1'b0}});

    // Previous-sample match history, tracked across every write state so FILL->ARMED edges count
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_match_r <= 1'b0;
        end else if (sample_en) begin
            prev_match_r <= match_s;
        end
    end

    // Mode mux, qualified by the ARMED state
    always_comb begin
        cond_s = 1'b0;
        case (mode)
            TRIG_LEVEL: cond_s = match_s;
            TRIG_EDGE:  cond_s = match_s & ~prev_match_r;
            TRIG_EXT:   cond_s = ext_trigger;
            TRIG_FORCE: cond_s = 1'b1;
            default:    cond_s = 1'b0;
        endcase
        if (armed) begin
            fire = cond_s;
        end else begin
            fire = 1'b0;
        end
    end

endmodule

// File: rtl/ila_capture_engine.sv
// Internal logic analyzer capture core: circular-buffer capture, trigger + holdoff, oldest-first readout.
// Build option ILA_TIMESTAMP_EN stores a 32-bit write timestamp in the upper bits of each sample.
module ila_capture_engine
    import ila_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_arm,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_trigger,
    input  logic [1:0]               i_trig_mode,
    input  logic [DATA_WIDTH-1:0]    i_trig_mask,
    input  logic [DATA_WIDTH-1:0]    i_trig_value,
    input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
    output logic                     o_primed,
    output logic                     o_triggered,
    output logic                     o_stopped,
    output logic [ADDR_WIDTH-1:0]    o_trig_addr,
    output logic                     o_valid,
    input  logic                     i_ready,
`ifdef ILA_TIMESTAMP_EN
    output logic [DATA_WIDTH+TS_WIDTH-1:0] o_data,
`else
    output logic [DATA_WIDTH-1:0]    o_data,
`endif
    output logic                     o_last
);

`ifdef ILA_TIMESTAMP_EN
    localparam int PW = DATA_WIDTH + TS_WIDTH;
`else
    localparam int PW = DATA_WIDTH;
`endif
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                   state_r, next_s;
    logic [ADDR_WIDTH-1:0]    wptr_r;
    logic [HOLDOFF_WIDTH-1:0] hold_cnt_r;
    logic                     primed_r, triggered_r, stopped_r;
    logic [ADDR_WIDTH-1:0]    trig_addr_r;
    logic                     write_s, fire_s, arm_s;
    logic [PW-1:0]            wdata_s;
    logic [PW-1:0]            mem [DEPTH];

    logic [ADDR_WIDTH:0]      rd_cnt_r;
    logic [ADDR_WIDTH-1:0]    raddr_s;
    logic [PW-1:0]            mem_q_r, skid_data_r, out_data_r;
    logic                     pend_r, pend_last_r, skid_valid_r, skid_last_r, out_valid_r, out_last_r;
    logic                     pop_s, out_take_s, issue_s, issue_last_s;
    logic [1:0]               occ_s;

    assign write_s = is_write_state(state_r);
    assign arm_s   = (state_r == IDLE) && i_arm;

`ifdef ILA_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_r;

    // Write timestamp: zero for the first sample after arm, +1 per written sample
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_r <= {TS_WIDTH{1'b0}};
        end else if (arm_s) begin
            ts_r <= {TS_WIDTH{1'b0}};
        end else if (write_s) begin
            ts_r <= ts_r + 32'd1;
        end
    end
    assign wdata_s = {ts_r, i_data};
`else
    assign wdata_s = i_data;
`endif

    ila_trigger_unit #(.DATA_WIDTH(DATA_WIDTH)) u_trigger (
        .clk         (clk),
        .reset       (reset),
        .data        (i_data),
        .mask        (i_trig_mask),
        .value       (i_trig_value),
        .mode        (i_trig_mode),
        .ext_trigger (i_trigger),
        .sample_en   (write_s),
        .armed       (state_r == ARMED),
        .fire        (fire_s)
    );

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_arm) next_s = FILL;
                else       next_s = IDLE;
            end
            FILL: begin
                if (wptr_r == {ADDR_WIDTH{1'b1}}) next_s = ARMED;
                else                              next_s = FILL;
            end
            ARMED: begin
                if (fire_s && (i_holdoff == {HOLDOFF_WIDTH{1'b0}})) next_s = READOUT;
                else if (fire_s)                                     next_s = HOLDOFF;
                else                                                 next_s = ARMED;
            end
            HOLDOFF: begin
                if (hold_cnt_r == HOLDOFF_WIDTH'(1)) next_s = READOUT;
                else                                 next_s = HOLDOFF;
            end
            READOUT: begin
                if (pop_s && out_last_r) next_s = READOUT == READOUT ? IDLE : IDLE;
                else                     next_s = READOUT;
            end
            default: next_s = IDLE;
        endcase
    end

    // Capture-side state: FSM, write pointer, holdoff counter, status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            wptr_r      <= {ADDR_WIDTH{1'b0}};
            hold_cnt_r  <= {HOLDOFF_WIDTH{1'b0}};
            trig_addr_r <= {ADDR_WIDTH{1'b0}};
            primed_r    <= 1'b0;
            triggered_r <= 1'b0;
            stopped_r   <= 1'b0;
        end else begin
            state_r <= next_s;
            if (arm_s) begin
                wptr_r <= {ADDR_WIDTH{1'b0}};
            end else if (write_s) begin
                wptr_r <= wptr_r + ADDR_WIDTH'(1);
            end
            if (fire_s) begin
                trig_addr_r <= wptr_r;
                hold_cnt_r  <= i_holdoff;
            end else if (state_r == HOLDOFF) begin
                hold_cnt_r  <= hold_cnt_r - HOLDOFF_WIDTH'(1);
            end
            primed_r    <= (next_s == ARMED) || (next_s == HOLDOFF) || (next_s == READOUT);
            triggered_r <= (next_s == HOLDOFF) || (next_s == READOUT);
            stopped_r   <= (next_s == READOUT);
        end
    end

    // Sample buffer with registered read port
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem[wptr_r] <= wdata_s;
        end
        if (issue_s) begin
            mem_q_r <= mem[raddr_s];
        end
    end

    // Readout flow control: at most two samples held (output + skid) counting the read in flight
    always_comb begin
        raddr_s      = wptr_r + rd_cnt_r[ADDR_WIDTH-1:0];
        pop_s        = out_valid_r & i_ready;
        out_take_s   = ~out_valid_r | i_ready;
        occ_s        = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, pend_r};
        issue_last_s = (rd_cnt_r == (ADDR_WIDTH+1)'(DEPTH-1));
        if ((state_r == READOUT) && !rd_cnt_r[ADDR_WIDTH] && ((occ_s - {1'b0, pop_s}) < 2'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Readout pipeline: read-in-flight flag, skid register, output register
    always_ff @(posedge clk) begin
        if (reset || (state_r != READOUT)) begin
            rd_cnt_r     <= {(ADDR_WIDTH+1){1'b0}};
            pend_r       <= 1'b0;
            pend_last_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
            skid_data_r  <= {PW{1'b0}};
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= {PW{1'b0}};
        end else begin
            if (issue_s) begin
                rd_cnt_r <= rd_cnt_r + (ADDR_WIDTH+1)'(1);
            end
            pend_r      <= issue_s;
            pend_last_r <= issue_s & issue_last_s;
            if (out_take_s) begin
                if (skid_valid_r) begin
                    out_valid_r  <= 1'b1;
                    out_data_r   <= skid_data_r;
                    out_last_r   <= skid_last_r;
                    skid_valid_r <= pend_r;
                    skid_data_r  <= mem_q_r;
                    skid_last_r  <= pend_last_r;
                end else if (pend_r) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= mem_q_r;
                    out_last_r  <= pend_last_r;
                end else begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            end else if (pend_r) begin
                skid_valid_r <= 1'b1;
                skid_data_r  <= mem_q_r;
                skid_last_r  <= pend_last_r;
            end
        end
    end

    assign o_primed    = primed_r;
    assign o_triggered = triggered_r;
    assign o_stopped   = stopped_r;
    assign o_trig_addr = trig_addr_r;
    assign o_valid     = out_valid_r;
    assign o_data      = out_data_r;
    assign o_last      = out_last_r;

endmodule

// File: tb/tb_ila_capture_engine.sv
// Self-checking bench for ila_capture_engine: the expected trigger index, stop index and readout
// window are derived from the stimulus sequence alone. Honours ILA_TIMESTAMP_EN when defined.
module tb_ila_capture_engine;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int HW    = 8;
    localparam int DEPTH = 2 ** AW;
    localparam int NMAX  = 256;
`ifdef ILA_TIMESTAMP_EN
    localparam int OW = DW + 32;
`else
    localparam int OW = DW;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          i_arm;
    logic [DW-1:0] i_data;
    logic          i_trigger;
    logic [1:0]    i_trig_mode;
    logic [DW-1:0] i_trig_mask;
    logic [DW-1:0] i_trig_value;
    logic [HW-1:0] i_holdoff;
    logic          o_primed, o_triggered, o_stopped;
    logic [AW-1:0] o_trig_addr;
    logic          o_valid;
    logic          i_ready;
    logic [OW-1:0] o_data;
    logic          o_last;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] d_q  [NMAX];
    logic          tr_q [NMAX];

    always #5 clk = ~clk;

    ila_capture_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_arm        (i_arm),
        .i_data       (i_data),
        .i_trigger    (i_trigger),
        .i_trig_mode  (i_trig_mode),
        .i_trig_mask  (i_trig_mask),
        .i_trig_value (i_trig_value),
        .i_holdoff    (i_holdoff),
        .o_primed     (o_primed),
        .o_triggered  (o_triggered),
        .o_stopped    (o_stopped),
        .o_trig_addr  (o_trig_addr),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_last       (o_last)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_match(input logic [DW-1:0] x, input logic [DW-1:0] m, input logic [DW-1:0] v);
        return ((x ^ v) & m) == '0;
    endfunction

    // Index of the first sample (counting from the first one after arm) that fires, or -1
    function automatic int find_trig(input int mode, input logic [DW-1:0] m, input logic [DW-1:0] v);
        for (int k = DEPTH; k < NMAX; k++) begin
            case (mode)
                0:       if (is_match(d_q[k], m, v)) return k;
                1:       if (is_match(d_q[k], m, v) && !is_match(d_q[k-1], m, v)) return k;
                2:       if (tr_q[k]) return k;
                default: return k;
            endcase
        end
        return -1;
    endfunction

    function automatic logic [63:0] exp_word(input int idx);
`ifdef ILA_TIMESTAMP_EN
        return {16'd0, 32'(idx), d_q[idx]};
`else
        return 64'(d_q[idx]);
`endif
    endfunction

    task automatic fill_avoid(input logic [DW-1:0] m, input logic [DW-1:0] v);
        for (int k = 0; k < NMAX; k++) begin
            d_q[k]  = DW'($urandom);
            if (is_match(d_q[k], m, v)) d_q[k] = d_q[k] ^ (m & (~m + 1'b1));
            tr_q[k] = 1'b0;
        end
    endtask

    task automatic run_capture(input int mode, input logic [DW-1:0] m, input logic [DW-1:0] v,
                               input int holdoff, input bit rnd_ready, input int abort_at);
        int t, s, j, cyc;
        bit prev_stall;
        logic [OW-1:0] prev_data;
        t = find_trig(mode, m, v);
        s = t + holdoff;
        i_trig_mode = 2'(mode); i_trig_mask = m; i_trig_value = v; i_holdoff = HW'(holdoff);
        i_ready = 1'b0;
        @(posedge clk); #1;
        i_arm = 1'b1; i_data = DW'($urandom);
        @(posedge clk); #1;
        i_arm = 1'b0; i_data = d_q[0]; i_trigger = tr_q[0];
        for (int k = 0; k <= s; k++) begin
            @(posedge clk); #1;
            if (abort_at >= 0 && k == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                check_val("abort_primed", 64'(o_primed), 64'(0));
                check_val("abort_triggered", 64'(o_triggered), 64'(0));
                check_val("abort_stopped", 64'(o_stopped), 64'(0));
                check_val("abort_valid", 64'(o_valid), 64'(0));
                check_val("abort_trig_addr", 64'(o_trig_addr), 64'(0));
                return;
            end
            check_val("primed", 64'(o_primed), 64'(k >= DEPTH - 1));
            check_val("triggered", 64'(o_triggered), 64'(k >= t));
            check_val("stopped", 64'(o_stopped), 64'(k >= s));
            check_val("capture_valid", 64'(o_valid), 64'(0));
            i_data = d_q[k+1]; i_trigger = tr_q[k+1];
            if (k >= t) i_holdoff = HW'($urandom);
        end
        check_val("trig_addr", 64'(o_trig_addr), 64'(t % DEPTH));
        j = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        while (j < DEPTH && cyc < 2000) begin
            if (prev_stall) begin
                check_val("stall_valid", 64'(o_valid), 64'(1));
                check_val("stall_data", 64'(o_data), 64'(prev_data));
            end
            i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && i_ready) begin
                check_val("rd_data", 64'(o_data), exp_word(s - DEPTH + 1 + j));
                check_val("rd_last", 64'(o_last), 64'(j == DEPTH - 1));
                j++;
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            i_data     = DW'($urandom);
            i_trigger  = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        if (j < DEPTH) check_val("readout_timeout", 64'(j), 64'(DEPTH));
        i_ready = 1'b0;
        check_val("end_valid", 64'(o_valid), 64'(0));
        check_val("end_stopped", 64'(o_stopped), 64'(0));
        check_val("end_triggered", 64'(o_triggered), 64'(0));
        check_val("end_primed", 64'(o_primed), 64'(0));
    endtask

    initial begin
        int mode, hold, t;
        logic [DW-1:0] m, v;
        reset = 1'b1; i_arm = 1'b0; i_data = '0; i_trigger = 1'b0; i_trig_mode = 2'b00;
        i_trig_mask = '0; i_trig_value = '0; i_holdoff = '0; i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_primed", 64'(o_primed), 64'(0));
        check_val("rst_triggered", 64'(o_triggered), 64'(0));
        check_val("rst_stopped", 64'(o_stopped), 64'(0));
        check_val("rst_trig_addr", 64'(o_trig_addr), 64'(0));
        check_val("rst_valid", 64'(o_valid), 64'(0));
        check_val("rst_last", 64'(o_last), 64'(0));
        check_val("rst_data", 64'(o_data), 64'(0));
        reset = 1'b0;

        // Force mode, counting data: window 4..19, trigger at address 0
        for (int k = 0; k < NMAX; k++) begin d_q[k] = DW'(k); tr_q[k] = 1'b0; end
        run_capture(3, '0, '0, 3, 1'b0, -1);

        // Level mode: match in FILL ignored, readout ends on the armed match
        fill_avoid(16'h00FF, 16'h0020);
        d_q[5] = 16'hAB20; d_q[25] = 16'h1220;
        run_capture(0, 16'h00FF, 16'h0020, 0, 1'b1, -1);

        // Edge mode: 10-cycle level hold fires once, on its first sample
        fill_avoid(16'h00FF, 16'h0020);
        for (int k = 20; k < 30; k++) d_q[k] = 16'h0020;
        d_q[40] = 16'h0020;
        run_capture(1, 16'h00FF, 16'h0020, 5, 1'b1, -1);

        // Edge straddling FILL->ARMED counts
        fill_avoid(16'h00FF, 16'h0020);
        d_q[16] = 16'h0020;
        run_capture(1, 16'h00FF, 16'h0020, 2, 1'b0, -1);

        // Level hold across FILL->ARMED is not an edge
        fill_avoid(16'h00FF, 16'h0020);
        for (int k = 14; k < 18; k++) d_q[k] = 16'h0020;
        d_q[22] = 16'h0020;
        run_capture(1, 16'h00FF, 16'h0020, 4, 1'b1, -1);

        // External trigger, pulse in FILL ignored, holdoff beyond DEPTH
        fill_avoid(16'hFFFF, 16'h0000);
        tr_q[3] = 1'b1; tr_q[30] = 1'b1; tr_q[31] = 1'b1;
        run_capture(2, '0, '0, 20, 1'b1, -1);

        // Reset during HOLDOFF, then a normal capture
        for (int k = 0; k < NMAX; k++) begin d_q[k] = DW'(k * 3); tr_q[k] = 1'b0; end
        run_capture(3, '0, '0, 10, 1'b0, DEPTH + 3);
        run_capture(3, '0, '0, 6, 1'b1, -1);

        // Randomized captures
        for (int n = 0; n < 8; n++) begin
            mode = $urandom_range(0, 3);
            m    = DW'(1) << $urandom_range(0, DW - 1);
            m    = m | (DW'(1) << $urandom_range(0, DW - 1));
            v    = DW'($urandom);
            hold = $urandom_range(0, 24);
            for (int k = 0; k < NMAX; k++) begin
                d_q[k]  = DW'($urandom);
                tr_q[k] = ($urandom_range(0, 7) == 0);
            end
            t = find_trig(mode, m, v);
            if (t < 0 || t + hold >= NMAX - 1) mode = 3;
            run_capture(mode, m, v, hold, 1'b1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
